// File: rtl/clip_seq_pkg.sv
// Shared types for the clip memory sequencer.
// Holds FSM states, clip select type and default widths.
package clip_seq_pkg;

  localparam int DEF_ADDR_W   = 17;
  localparam int DEF_SAMPLE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    REC,
    PLAY,
    PLAY_RD
  } state_t;

  typedef logic clip_id_t;

endpackage

// File: rtl/clip_addr_counter.sv
// Loadable, clearable address counter.
// Saturates at limit and flags the terminal count.
module clip_addr_counter #(
  parameter int W = 17
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         at_limit
);

  assign at_limit = (count == limit);

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc && !at_limit) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/clip_memory_sequencer.sv
// Record/playback sequencer for two clip memories.
// Owns the shared address bus and per-clip length/valid.
module clip_memory_sequencer
  import clip_seq_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int SAMPLE_W   = DEF_SAMPLE_W,
  parameter int CLIP_DEPTH = 96000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                play_req,
  input  logic                record_req,
  input  logic                stop_req,
  input  logic                clip_sel,
  input  logic                des_valid,
  input  logic [SAMPLE_W-1:0] des_data,
  input  logic                ser_ready,
  output logic                ser_valid,
  output logic [SAMPLE_W-1:0] ser_data,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [SAMPLE_W-1:0] mem_wdata,
  input  logic [SAMPLE_W-1:0] mem1_rdata,
  input  logic [SAMPLE_W-1:0] mem2_rdata,
  output logic                mem1_en,
  output logic                mem1_wen,
  output logic                mem2_en,
  output logic                mem2_wen,
  output logic                enable_des,
  output logic                enable_ser,
  output logic                busy,
  output logic                done,
  output logic [1:0]          clip_valid
);

  // One extra bit so a full clip length is representable.
  localparam int LEN_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(CLIP_DEPTH - 1);

  typedef logic [LEN_W-1:0] len_t;

  state_t   state, state_n;
  clip_id_t sel, sel_n;

  logic [ADDR_W-1:0] addr;
  logic              at_last;
  logic              cnt_clr;
  logic              cnt_load;
  logic              cnt_inc;

  len_t       clip_len [2];
  len_t       len_n;
  logic       len_we;
  logic [1:0] valid_q, valid_n;

  logic end_pend, end_pend_n;
  logic done_n;
  logic ser_valid_n;
  logic mem_en, mem_wen;

  logic [SAMPLE_W-1:0] rdata;

  clip_addr_counter #(
    .W (ADDR_W)
  ) u_addr (
    .clock    (clock),
    .reset    (reset),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val ('0),
    .inc      (cnt_inc),
    .limit    (LAST),
    .count    (addr),
    .at_limit (at_last)
  );

  always_comb begin
    state_n     = state;
    sel_n       = sel;
    valid_n     = valid_q;
    len_we      = 1'b0;
    len_n       = '0;
    end_pend_n  = end_pend;
    done_n      = 1'b0;
    ser_valid_n = 1'b0;
    cnt_clr     = 1'b0;
    cnt_load    = 1'b0;
    cnt_inc     = 1'b0;
    mem_en      = 1'b0;
    mem_wen     = 1'b0;
    unique case (state)
      IDLE: begin
        if (play_req) begin
          if (valid_q[clip_sel]) begin
            sel_n      = clip_sel;
            cnt_load   = 1'b1;
            end_pend_n = 1'b0;
            state_n    = PLAY;
          end
        end else if (record_req) begin
          sel_n             = clip_sel;
          cnt_load          = 1'b1;
          valid_n[clip_sel] = 1'b0;
          state_n           = REC;
        end
      end
      REC: begin
        mem_en  = des_valid;
        mem_wen = des_valid;
        if ((des_valid && at_last) || stop_req) begin
          len_we       = 1'b1;
          len_n        = {1'b0, addr} + LEN_W'(des_valid);
          valid_n[sel] = (len_n != '0);
          done_n       = 1'b1;
          cnt_clr      = 1'b1;
          state_n      = IDLE;
        end else begin
          cnt_inc = des_valid;
        end
      end
      PLAY: begin
        if (({1'b0, addr} == clip_len[sel]) ||
            stop_req || end_pend) begin
          done_n  = 1'b1;
          cnt_clr = 1'b1;
          state_n = IDLE;
        end else if (ser_ready) begin
          mem_en  = 1'b1;
          state_n = PLAY_RD;
        end
      end
      PLAY_RD: begin
        ser_valid_n = 1'b1;
        cnt_inc     = 1'b1;
        state_n     = PLAY;
        // Last slot cannot be stepped past; end like a stop.
        if (stop_req || at_last) end_pend_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      sel         <= '0;
      valid_q     <= '0;
      clip_len[0] <= '0;
      clip_len[1] <= '0;
      end_pend    <= 1'b0;
      done        <= 1'b0;
      ser_valid   <= 1'b0;
      ser_data    <= '0;
    end else begin
      state     <= state_n;
      sel       <= sel_n;
      valid_q   <= valid_n;
      end_pend  <= end_pend_n;
      done      <= done_n;
      ser_valid <= ser_valid_n;
      if (len_we) clip_len[sel] <= len_n;
      if (ser_valid_n) ser_data <= rdata;
    end
  end

  assign rdata      = sel ? mem2_rdata : mem1_rdata;
  assign mem_addr   = addr;
  assign mem_wdata  = des_data;
  assign mem1_en    = mem_en  & ~sel;
  assign mem1_wen   = mem_wen & ~sel;
  assign mem2_en    = mem_en  &  sel;
  assign mem2_wen   = mem_wen &  sel;
  assign enable_des = (state == REC);
  assign enable_ser = (state == PLAY) ||
                      (state == PLAY_RD);
  assign busy       = (state != IDLE);
  assign clip_valid = valid_q;

endmodule

// File: tb/tb_clip_memory_sequencer.sv
// Randomized bench for clip_memory_sequencer.
// Transaction model of clips drives a per-cycle compare.
module tb_clip_memory_sequencer;

  localparam int AW    = 17;
  localparam int SW    = 8;
  localparam int DEPTH = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          play_req = 1'b0;
  logic          record_req = 1'b0;
  logic          stop_req = 1'b0;
  logic          clip_sel = 1'b0;
  logic          des_valid = 1'b0;
  logic [SW-1:0] des_data = '0;
  logic          ser_ready = 1'b0;
  logic          ser_valid;
  logic [SW-1:0] ser_data;
  logic [AW-1:0] mem_addr;
  logic [SW-1:0] mem_wdata;
  logic [SW-1:0] mem1_rdata;
  logic [SW-1:0] mem2_rdata;
  logic          mem1_en, mem1_wen;
  logic          mem2_en, mem2_wen;
  logic          enable_des, enable_ser;
  logic          busy, done;
  logic [1:0]    clip_valid;

  clip_memory_sequencer #(
    .ADDR_W     (AW),
    .SAMPLE_W   (SW),
    .CLIP_DEPTH (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .play_req   (play_req),
    .record_req (record_req),
    .stop_req   (stop_req),
    .clip_sel   (clip_sel),
    .des_valid  (des_valid),
    .des_data   (des_data),
    .ser_ready  (ser_ready),
    .ser_valid  (ser_valid),
    .ser_data   (ser_data),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem1_rdata (mem1_rdata),
    .mem2_rdata (mem2_rdata),
    .mem1_en    (mem1_en),
    .mem1_wen   (mem1_wen),
    .mem2_en    (mem2_en),
    .mem2_wen   (mem2_wen),
    .enable_des (enable_des),
    .enable_ser (enable_ser),
    .busy       (busy),
    .done       (done),
    .clip_valid (clip_valid)
  );

  always #5 clock = ~clock;

  typedef struct {
    int clip;
    int addr;
    logic [SW-1:0] data;
  } wr_t;
  typedef struct {
    int cyc;
    int clip;
    int addr;
  } rd_t;
  typedef struct {
    int cyc;
    logic [SW-1:0] data;
  } sv_t;

  wr_t wq[$];
  rd_t rq[$];
  sv_t sq[$];

  logic [SW-1:0] mclip [2][DEPTH];
  int            mlen  [2];
  bit            mvalid[2];
  logic [SW-1:0] obs_q[$];
  logic [SW-1:0] pat[$];
  logic [SW-1:0] lit [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  int cyc = 0;
  int exp_done = -1;
  int n_chk = 0;
  int n_pass = 0;

  logic [SW-1:0] m1 [DEPTH];
  logic [SW-1:0] m2 [DEPTH];

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    if (mem_addr < AW'(DEPTH)) begin
      if (mem1_en) begin
        if (mem1_wen) m1[int'(mem_addr)] <= mem_wdata;
        else mem1_rdata <= m1[int'(mem_addr)];
      end
      if (mem2_en) begin
        if (mem2_wen) m2[int'(mem_addr)] <= mem_wdata;
        else mem2_rdata <= m2[int'(mem_addr)];
      end
    end
  end

  task automatic check(input bit ok, input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, got, exp);
  endtask

  task automatic check_eq(input string name,
                          input logic [63:0] got,
                          input logic [63:0] exp);
    check(got === exp, name, got, exp);
  endtask

  always @(negedge clock) begin : cmp
    wr_t w;
    rd_t r;
    sv_t s;
    if (reset) begin
      if (mem1_wen || mem2_wen)
        check_eq("wen_has_en",
          (mem1_wen & mem1_en) | (mem2_wen & mem2_en), 1);
      if (mem1_en || mem2_en) begin
        check_eq("single_mem_en", mem1_en & mem2_en, 0);
        check_eq("addr_bound",
                 64'(mem_addr < AW'(DEPTH)), 1);
      end
      if ((mem1_en & mem1_wen) | (mem2_en & mem2_wen)) begin
        check(wq.size() > 0, "write_expected", wq.size(), 1);
        if (wq.size() > 0) begin
          w = wq.pop_front();
          check_eq("wr_mem", mem2_en, w.clip);
          check_eq("wr_addr", mem_addr, w.addr);
          check_eq("wr_data", mem_wdata, w.data);
        end
      end else if (wq.size() > 0) begin
        w = wq.pop_front();
        check_eq("write_missing", mem1_wen | mem2_wen, 1);
      end
      if ((mem1_en & ~mem1_wen) | (mem2_en & ~mem2_wen)) begin
        check(rq.size() > 0, "read_expected", rq.size(), 1);
        if (rq.size() > 0) begin
          r = rq.pop_front();
          check_eq("rd_cyc", cyc, r.cyc);
          check_eq("rd_mem", mem2_en, r.clip);
          check_eq("rd_addr", mem_addr, r.addr);
        end
      end else if (rq.size() > 0 && rq[0].cyc <= cyc) begin
        r = rq.pop_front();
        check_eq("read_missing", mem1_en | mem2_en, 1);
      end
      if (ser_valid) begin
        check(sq.size() > 0, "ser_expected", sq.size(), 1);
        if (sq.size() > 0) begin
          s = sq.pop_front();
          check_eq("ser_cyc", cyc, s.cyc);
          check_eq("ser_data", ser_data, s.data);
        end
        obs_q.push_back(ser_data);
      end else if (sq.size() > 0 && sq[0].cyc <= cyc) begin
        s = sq.pop_front();
        check_eq("ser_valid_missing", ser_valid, 1);
      end
      if (done || cyc == exp_done)
        check_eq("done_pulse", done, cyc == exp_done);
    end
  end

  task automatic check_idle_reset();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_clip_valid", clip_valid, 2'b00);
    check_eq("rst_mem_en",
             {mem1_en, mem1_wen, mem2_en, mem2_wen}, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_ser_valid", ser_valid, 0);
    check_eq("rst_ser_data", ser_data, 0);
    check_eq("rst_en_des", enable_des, 0);
    check_eq("rst_en_ser", enable_ser, 0);
  endtask

  // n > DEPTH: continuous samples, auto end; else n then stop.
  task automatic do_record(input int c, input int n,
                           input bit stop_same);
    int cnt;
    int sent;
    bit fin;
    logic [SW-1:0] d;
    @(posedge clock); #1;
    record_req = 1'b1;
    clip_sel   = c[0];
    @(posedge clock); #1;
    record_req = 1'b0;
    mvalid[c] = 1'b0;
    cnt  = 0;
    sent = 0;
    fin  = 1'b0;
    check_eq("rec_enable_des", enable_des, 1);
    check_eq("rec_valid_cleared", clip_valid[c], 0);
    for (int t = 0; t < 200 && !fin; t++) begin
      d = (pat.size() > sent) ? pat[sent] : SW'($urandom);
      des_valid = (n > DEPTH) ||
                  (sent < n && $urandom_range(0, 3) != 0);
      des_data = d;
      stop_req = 1'b0;
      if (des_valid) begin
        wq.push_back(wr_t'{c, cnt, d});
        mclip[c][cnt] = d;
        cnt++;
        sent++;
      end
      if (cnt == DEPTH) begin
        fin = 1'b1;
      end else if (n <= DEPTH && sent == n &&
                   (!des_valid || stop_same)) begin
        stop_req = 1'b1;
        fin = 1'b1;
      end
      if (fin) begin
        exp_done  = cyc + 1;
        mlen[c]   = cnt;
        mvalid[c] = (cnt != 0);
      end
      @(posedge clock); #1;
    end
    stop_req = 1'b0;
    check(fin, "rec_timeout", fin, 1);
    check_eq("rec_busy_end", busy, 0);
    check_eq("rec_clip_valid", clip_valid,
             {mvalid[1], mvalid[0]});
    if (des_valid) begin
      repeat (2) @(posedge clock);
      #1;
    end
    des_valid = 1'b0;
  endtask

  // stop_at = loop cycle to raise stop_req, -1 for none.
  task automatic do_play(input int c, input int stop_at,
                         input bit hold, input bit with_rec);
    int idx;
    int len;
    bit rd;
    bit pend;
    bit fin;
    @(posedge clock); #1;
    play_req   = 1'b1;
    clip_sel   = c[0];
    record_req = with_rec && mvalid[c];
    @(posedge clock); #1;
    play_req   = 1'b0;
    record_req = 1'b0;
    if (!mvalid[c]) begin
      check_eq("play_empty_busy", busy, 0);
      return;
    end
    check_eq("play_enable_ser", enable_ser, 1);
    check_eq("play_not_rec", enable_des, 0);
    obs_q.delete();
    len  = mlen[c];
    idx  = 0;
    rd   = 1'b0;
    pend = 1'b0;
    fin  = 1'b0;
    for (int t = 0; t < 200 && !fin; t++) begin
      ser_ready = hold || ($urandom_range(0, 1) == 1);
      stop_req  = (t == stop_at);
      if (rd) begin
        sq.push_back(sv_t'{cyc + 1, mclip[c][idx]});
        idx++;
        rd   = 1'b0;
        pend = pend | stop_req;
      end else if (idx == len || pend || stop_req) begin
        exp_done = cyc + 1;
        fin = 1'b1;
      end else if (ser_ready) begin
        rq.push_back(rd_t'{cyc, c, idx});
        rd = 1'b1;
      end
      @(posedge clock); #1;
    end
    ser_ready = 1'b0;
    stop_req  = 1'b0;
    check(fin, "play_timeout", fin, 1);
    check_eq("play_busy_end", busy, 0);
  endtask

  task automatic do_reset_mid();
    @(posedge clock); #1;
    record_req = 1'b1;
    clip_sel   = 1'b0;
    @(posedge clock); #1;
    record_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      des_valid = 1'b1;
      des_data  = SW'($urandom);
      wq.push_back(wr_t'{0, i, des_data});
      @(posedge clock); #1;
    end
    des_valid = 1'b0;
    reset     = 1'b0;
    @(posedge clock); #1;
    reset     = 1'b1;
    mvalid    = '{1'b0, 1'b0};
    mlen      = '{0, 0};
    exp_done  = -1;
    check_idle_reset();
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    check_idle_reset();

    do_record(1, 3, 1'b1);
    do_reset_mid();

    pat = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_record(1, 4, 1'b0);
    pat.delete();
    check_eq("lit_valid_clip2", clip_valid, 2'b10);
    do_play(1, -1, 1'b1, 1'b0);
    check_eq("lit_play_count", obs_q.size(), 4);
    for (int i = 0; i < 4 && i < obs_q.size(); i++)
      check_eq("lit_play_data", obs_q[i], lit[i]);

    do_play(0, -1, 1'b1, 1'b0);
    do_play(1, -1, 1'b0, 1'b1);

    do_record(0, 12, 1'b0);
    check_eq("lit_valid_both", clip_valid, 2'b11);
    do_play(0, -1, 1'b0, 1'b0);
    check_eq("lit_full_count", obs_q.size(), DEPTH);

    do_play(0, 1, 1'b1, 1'b0);
    check_eq("lit_stop_rd_count", obs_q.size(), 1);

    do_record(0, 0, 1'b0);
    check_eq("lit_empty_rec", clip_valid, 2'b10);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 1) == 1)
        do_record(int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 10)),
                  1'($urandom_range(0, 1)));
      else
        do_play(int'($urandom_range(0, 1)),
                ($urandom_range(0, 1) == 1) ? -1 :
                  int'($urandom_range(0, 20)),
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
